// File: rtl/miriscv_lsu_pkg.sv
// miriscv_lsu_pkg: shared definitions for the XLEN-parametrised load-store unit.
//   MEM_ACCESS_*  : access size codes carried on lsu_size_i
//   lsu_state_e   : LSU FSM state encoding
//   access_bytes  : byte count of an access for a given size code (0 = invalid)
package miriscv_lsu_pkg;

  localparam int unsigned MEM_ACCESS_W = 3;

  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_WORD  = 3'd0;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_HALF  = 3'd1;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_BYTE  = 3'd2;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UHALF = 3'd3;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UBYTE = 3'd4;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_DWORD = 3'd5;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UWORD = 3'd6;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_REQ2,
    LSU_WAIT2
  } lsu_state_e;

  function automatic logic [3:0] access_bytes(input logic [MEM_ACCESS_W-1:0] size);
    logic [3:0] n;
    case (size)
      MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: n = 4'd1;
      MEM_ACCESS_HALF, MEM_ACCESS_UHALF: n = 4'd2;
      MEM_ACCESS_WORD, MEM_ACCESS_UWORD: n = 4'd4;
      MEM_ACCESS_DWORD:                  n = 4'd8;
      default:                           n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/miriscv_lsu_align.sv
// miriscv_lsu_align: combinational byte-lane steering for one bus beat.
//   size_i/off_i/beat_i : access size, byte offset in the bus word, beat index
//   wdata_i -> wdata_o  : store data shifted onto its lanes for this beat
//   be_o                : byte enables for this beat
//   rdata_lo_i/hi_i     : first and second bus words (same word for single beats)
//   rdata_o             : merged, extracted and sign/zero-extended load data
module miriscv_lsu_align
  import miriscv_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [MEM_ACCESS_W-1:0]    size_i,
  input  logic [$clog2(XLEN/8)-1:0]  off_i,
  input  logic                       beat_i,
  input  logic [XLEN-1:0]            wdata_i,
  input  logic [XLEN-1:0]            rdata_lo_i,
  input  logic [XLEN-1:0]            rdata_hi_i,
  output logic [XLEN/8-1:0]          be_o,
  output logic [XLEN-1:0]            wdata_o,
  output logic [XLEN-1:0]            rdata_o
);

  localparam int unsigned BE_W = XLEN / 8;

  logic [3:0]        nbytes;
  logic [6:0]        nbits;
  logic              is_signed;
  logic              sign_bit;
  logic [BE_W-1:0]   size_mask;
  logic [2*BE_W-1:0] be_full;
  logic [2*XLEN-1:0] wd_full;
  logic [XLEN-1:0]   raw;

  assign nbytes = access_bytes(size_i);
  assign nbits  = {nbytes, 3'b000};

  always_comb begin
    size_mask = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      size_mask[i] = (i < 32'(nbytes));
    end
  end

  // Shifting into a double-width vector gives both beats at once: the low
  // half is the first beat, the overflow into the high half is the second.
  assign be_full = {{BE_W{1'b0}}, size_mask} << off_i;
  assign wd_full = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};
  assign be_o    = beat_i ? be_full[2*BE_W-1:BE_W] : be_full[BE_W-1:0];
  assign wdata_o = beat_i ? wd_full[2*XLEN-1:XLEN] : wd_full[XLEN-1:0];

  // Merge both beats, then bring the addressed byte down to lane 0.
  assign raw = XLEN'({rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000});

  assign is_signed = (size_i == MEM_ACCESS_WORD) || (size_i == MEM_ACCESS_HALF) ||
                     (size_i == MEM_ACCESS_BYTE);

  always_comb begin
    case (nbytes)
      4'd1:    sign_bit = raw[7];
      4'd2:    sign_bit = raw[15];
      4'd4:    sign_bit = raw[31];
      default: sign_bit = raw[XLEN-1];
    endcase
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      rdata_o[i] = (i < 32'(nbits)) ? raw[i] : (is_signed & sign_bit);
    end
  end

endmodule

// File: rtl/miriscv_lsu_xlen.sv
// miriscv_lsu_xlen: XLEN-parametrised load-store unit (XLEN = 32 or 64).
// Turns one core request (lsu_*) into one or two req/gnt/rvalid bus beats
// (data_*), steering byte lanes and extending load data.
//   Core side : lsu_req_i/we_i/size_i/addr_i/wdata_i in,
//               lsu_rdata_o/done_o/err_o/busy_o out
//   Bus side  : data_req_o/we_o/be_o/addr_o/wdata_o out,
//               data_gnt_i/rvalid_i/rdata_i in
// Optional feature macro MIRISCV_LSU_MISALIGN_EN: when defined, misaligned
// accesses are performed (split into two beats when crossing a bus word);
// when undefined they complete immediately with an error.
module miriscv_lsu_xlen
  import miriscv_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [MEM_ACCESS_W-1:0] lsu_size_i,
  input  logic [XLEN-1:0]         lsu_addr_i,
  input  logic [XLEN-1:0]         lsu_wdata_i,
  output logic [XLEN-1:0]         lsu_rdata_o,
  output logic                    lsu_done_o,
  output logic                    lsu_err_o,
  output logic                    lsu_busy_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  input  logic [XLEN-1:0]         data_rdata_i,
  output logic                    data_we_o,
  output logic [XLEN/8-1:0]       data_be_o,
  output logic [XLEN-1:0]         data_addr_o,
  output logic [XLEN-1:0]         data_wdata_o
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);

  lsu_state_e              state_q, state_d;
  logic                    we_q, we_d;
  logic [MEM_ACCESS_W-1:0] size_q, size_d;
  logic [OFF_W-1:0]        off_q, off_d;
  logic [XLEN-1:0]         wdata_q, wdata_d;
  logic [XLEN-1:0]         rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    data_req_q, data_req_d;
  logic                    data_we_q, data_we_d;
  logic [BE_W-1:0]         data_be_q, data_be_d;
  logic [XLEN-1:0]         data_addr_q, data_addr_d;
  logic [XLEN-1:0]         data_wdata_q, data_wdata_d;
`ifdef MIRISCV_LSU_MISALIGN_EN
  logic                    split_q, split_d;
  logic [XLEN-1:0]         rbuf_q, rbuf_d;
`endif

  // Request legality, evaluated on the live inputs in IDLE.
  logic [3:0] acc_n;
  logic [4:0] off5, n5;
  logic       size_bad, store_bad, illegal;

  assign acc_n     = access_bytes(lsu_size_i);
  assign off5      = 5'(lsu_addr_i[OFF_W-1:0]);
  assign n5        = {1'b0, acc_n};
  assign size_bad  = (lsu_size_i == 3'd7) ||
                     ((XLEN == 32) && ((lsu_size_i == MEM_ACCESS_DWORD) ||
                                       (lsu_size_i == MEM_ACCESS_UWORD)));
  assign store_bad = lsu_we_i && ((lsu_size_i == MEM_ACCESS_UHALF) ||
                                  (lsu_size_i == MEM_ACCESS_UBYTE) ||
                                  (lsu_size_i == MEM_ACCESS_UWORD));
`ifdef MIRISCV_LSU_MISALIGN_EN
  logic split_in;
  assign illegal  = size_bad || store_bad;
  assign split_in = (off5 + n5) > 5'(BE_W);
`else
  assign illegal  = size_bad || store_bad || (|(off5 & (n5 - 5'd1)));
`endif

  // Lane steering: live inputs while accepting (beat 0), captured request
  // afterwards (beat 1 issue and load data extraction).
  logic                    idle;
  logic [MEM_ACCESS_W-1:0] a_size;
  logic [OFF_W-1:0]        a_off;
  logic [XLEN-1:0]         a_wdata, a_rlo;
  logic [BE_W-1:0]         a_be;
  logic [XLEN-1:0]         a_wdata_sh, a_rdata;

  assign idle    = (state_q == LSU_IDLE);
  assign a_size  = idle ? lsu_size_i : size_q;
  assign a_off   = idle ? lsu_addr_i[OFF_W-1:0] : off_q;
  assign a_wdata = idle ? lsu_wdata_i : wdata_q;
`ifdef MIRISCV_LSU_MISALIGN_EN
  assign a_rlo   = (state_q == LSU_WAIT2) ? rbuf_q : data_rdata_i;
`else
  assign a_rlo   = data_rdata_i;
`endif

  miriscv_lsu_align #(.XLEN(XLEN)) u_align (
    .size_i     (a_size),
    .off_i      (a_off),
    .beat_i     (!idle),
    .wdata_i    (a_wdata),
    .rdata_lo_i (a_rlo),
    .rdata_hi_i (data_rdata_i),
    .be_o       (a_be),
    .wdata_o    (a_wdata_sh),
    .rdata_o    (a_rdata)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    data_req_d   = data_req_q;
    data_we_d    = data_we_q;
    data_be_d    = data_be_q;
    data_addr_d  = data_addr_q;
    data_wdata_d = data_wdata_q;
`ifdef MIRISCV_LSU_MISALIGN_EN
    split_d      = split_q;
    rbuf_d       = rbuf_q;
`endif
    case (state_q)
      LSU_IDLE: begin
        // done_q blocks the request the core still holds in its done cycle.
        if (lsu_req_i && !done_q) begin
          we_d    = lsu_we_i;
          size_d  = lsu_size_i;
          off_d   = lsu_addr_i[OFF_W-1:0];
          wdata_d = lsu_wdata_i;
`ifdef MIRISCV_LSU_MISALIGN_EN
          split_d = split_in;
`endif
          if (illegal) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d      = LSU_REQ;
            data_req_d   = 1'b1;
            data_we_d    = lsu_we_i;
            data_be_d    = a_be;
            data_addr_d  = {lsu_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            data_wdata_d = a_wdata_sh;
          end
        end
      end
      LSU_REQ: begin
        if (data_gnt_i) begin
          data_req_d = 1'b0;
          state_d    = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        if (data_rvalid_i) begin
`ifdef MIRISCV_LSU_MISALIGN_EN
          if (split_q) begin
            rbuf_d       = data_rdata_i;
            state_d      = LSU_REQ2;
            data_req_d   = 1'b1;
            data_addr_d  = data_addr_q + XLEN'(BE_W);
            data_be_d    = a_be;
            data_wdata_d = a_wdata_sh;
          end else
`endif
          begin
            state_d = LSU_IDLE;
            done_d  = 1'b1;
            rdata_d = we_q ? '0 : a_rdata;
          end
        end
      end
`ifdef MIRISCV_LSU_MISALIGN_EN
      LSU_REQ2: begin
        if (data_gnt_i) begin
          data_req_d = 1'b0;
          state_d    = LSU_WAIT2;
        end
      end
      LSU_WAIT2: begin
        if (data_rvalid_i) begin
          state_d = LSU_IDLE;
          done_d  = 1'b1;
          rdata_d = we_q ? '0 : a_rdata;
        end
      end
`endif
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= LSU_IDLE;
      we_q         <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_be_q    <= '0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
`ifdef MIRISCV_LSU_MISALIGN_EN
      split_q      <= 1'b0;
      rbuf_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      data_req_q   <= data_req_d;
      data_we_q    <= data_we_d;
      data_be_q    <= data_be_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
`ifdef MIRISCV_LSU_MISALIGN_EN
      split_q      <= split_d;
      rbuf_q       <= rbuf_d;
`endif
    end
  end

  assign lsu_rdata_o  = rdata_q;
  assign lsu_done_o   = done_q;
  assign lsu_err_o    = err_q;
  assign lsu_busy_o   = (state_q != LSU_IDLE) || done_q;
  assign data_req_o   = data_req_q;
  assign data_we_o    = data_we_q;
  assign data_be_o    = data_be_q;
  assign data_addr_o  = data_addr_q;
  assign data_wdata_o = data_wdata_q;

endmodule

// File: tb/tb_miriscv_lsu_xlen.sv
// tb_miriscv_lsu_xlen: directed self-checking bench for miriscv_lsu_xlen,
// with one XLEN=32 instance (s_*) and one XLEN=64 instance (w_*).
module tb_miriscv_lsu_xlen;
  import miriscv_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_req, s_we, s_done, s_err, s_busy, s_dreq, s_gnt, s_rvalid, s_dwe;
  logic [2:0]  s_size;
  logic [31:0] s_addr, s_wdata, s_rdata, s_drdata, s_daddr, s_dwdata;
  logic [3:0]  s_be;

  logic        w_req, w_we, w_done, w_err, w_busy, w_dreq, w_gnt, w_rvalid, w_dwe;
  logic [2:0]  w_size;
  logic [63:0] w_addr, w_wdata, w_rdata, w_drdata, w_daddr, w_dwdata;
  logic [7:0]  w_be;

  int n_checks = 0;
  int n_fail   = 0;

  miriscv_lsu_xlen #(.XLEN(32)) u_dut32 (
    .clk_i(clk), .rst_i(rst),
    .lsu_req_i(s_req), .lsu_we_i(s_we), .lsu_size_i(s_size), .lsu_addr_i(s_addr),
    .lsu_wdata_i(s_wdata), .lsu_rdata_o(s_rdata), .lsu_done_o(s_done), .lsu_err_o(s_err),
    .lsu_busy_o(s_busy), .data_req_o(s_dreq), .data_gnt_i(s_gnt), .data_rvalid_i(s_rvalid),
    .data_rdata_i(s_drdata), .data_we_o(s_dwe), .data_be_o(s_be), .data_addr_o(s_daddr),
    .data_wdata_o(s_dwdata)
  );

  miriscv_lsu_xlen #(.XLEN(64)) u_dut64 (
    .clk_i(clk), .rst_i(rst),
    .lsu_req_i(w_req), .lsu_we_i(w_we), .lsu_size_i(w_size), .lsu_addr_i(w_addr),
    .lsu_wdata_i(w_wdata), .lsu_rdata_o(w_rdata), .lsu_done_o(w_done), .lsu_err_o(w_err),
    .lsu_busy_o(w_busy), .data_req_o(w_dreq), .data_gnt_i(w_gnt), .data_rvalid_i(w_rvalid),
    .data_rdata_i(w_drdata), .data_we_o(w_dwe), .data_be_o(w_be), .data_addr_o(w_daddr),
    .data_wdata_o(w_dwdata)
  );

  task automatic idle_inputs();
    s_req = 0; s_we = 0; s_size = '0; s_addr = '0; s_wdata = '0;
    s_gnt = 0; s_rvalid = 0; s_drdata = '0;
    w_req = 0; w_we = 0; w_size = '0; w_addr = '0; w_wdata = '0;
    w_gnt = 0; w_rvalid = 0; w_drdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({s_rdata, s_done, s_err, s_busy, s_dreq, s_dwe, s_be, s_daddr, s_dwdata} !== '0) begin
      n_fail++; $display("FAIL reset32 outputs: got rdata=%h done=%b err=%b busy=%b req=%b, required all 0",
                         s_rdata, s_done, s_err, s_busy, s_dreq);
    end
    n_checks++;
    if ({w_rdata, w_done, w_err, w_busy, w_dreq, w_dwe, w_be, w_daddr, w_dwdata} !== '0) begin
      n_fail++; $display("FAIL reset64 outputs: got rdata=%h done=%b err=%b busy=%b req=%b, required all 0",
                         w_rdata, w_done, w_err, w_busy, w_dreq);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_byte();
    s_req = 1; s_we = 0; s_size = MEM_ACCESS_BYTE; s_addr = 32'h1003;      // cycle 0
    @(negedge clk);                                                         // cycle 1
    n_checks++; if (s_dreq !== 1'b1) begin n_fail++; $display("FAIL lb req: got %b required 1", s_dreq); end
    n_checks++; if (s_daddr !== 32'h1000) begin n_fail++; $display("FAIL lb addr: got %h required 00001000", s_daddr); end
    n_checks++; if (s_be !== 4'b1000) begin n_fail++; $display("FAIL lb be: got %b required 1000", s_be); end
    n_checks++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL lb busy: got %b required 1", s_busy); end
    s_gnt = 1;
    @(negedge clk);                                                         // cycle 2
    n_checks++; if (s_dreq !== 1'b0) begin n_fail++; $display("FAIL lb req_drop: got %b required 0", s_dreq); end
    n_checks++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL lb early_done: got %b required 0", s_done); end
    s_gnt = 0; s_rvalid = 1; s_drdata = 32'h80123456;
    @(negedge clk);                                                         // cycle 3
    n_checks++; if (s_done !== 1'b1) begin n_fail++; $display("FAIL lb done: got %b required 1", s_done); end
    n_checks++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL lb err: got %b required 0", s_err); end
    n_checks++; if (s_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb rdata: got %h required ffffff80", s_rdata); end
    s_rvalid = 0; s_drdata = '0;                                            // core still holds req
    @(negedge clk);                                                         // cycle 4
    n_checks++; if (s_dreq !== 1'b0) begin n_fail++; $display("FAIL lb reaccept: got req %b required 0", s_dreq); end
    n_checks++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL lb done_pulse: got %b required 0", s_done); end
    n_checks++; if (s_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb rdata_hold: got %h required ffffff80", s_rdata); end
    s_req = 0;
    @(negedge clk);
  endtask

  task automatic test_store_half();
    s_req = 1; s_we = 1; s_size = MEM_ACCESS_HALF; s_addr = 32'h1002; s_wdata = 32'h0000ABCD;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (s_dreq !== 1'b1) begin n_fail++; $display("FAIL sh req c%0d: got %b required 1", c, s_dreq); end
      n_checks++; if (s_daddr !== 32'h1000) begin n_fail++; $display("FAIL sh addr c%0d: got %h required 00001000", c, s_daddr); end
      n_checks++; if (s_be !== 4'b1100) begin n_fail++; $display("FAIL sh be c%0d: got %b required 1100", c, s_be); end
      n_checks++; if (s_dwdata !== 32'hABCD0000) begin n_fail++; $display("FAIL sh wdata c%0d: got %h required abcd0000", c, s_dwdata); end
      n_checks++; if (s_dwe !== 1'b1) begin n_fail++; $display("FAIL sh we c%0d: got %b required 1", c, s_dwe); end
      if (c == 3) s_gnt = 1;
    end
    @(negedge clk);
    n_checks++; if (s_dreq !== 1'b0) begin n_fail++; $display("FAIL sh req_drop: got %b required 0", s_dreq); end
    s_gnt = 0; s_rvalid = 1;
    @(negedge clk);
    n_checks++; if ({s_done, s_err} !== 2'b10) begin n_fail++; $display("FAIL sh done_err: got %b required 10", {s_done, s_err}); end
    s_rvalid = 0; s_req = 0; s_we = 0;
    @(negedge clk);
  endtask

  task automatic test_misalign_word();
    s_req = 1; s_we = 0; s_size = MEM_ACCESS_WORD; s_addr = 32'h1002;
`ifdef MIRISCV_LSU_MISALIGN_EN
    @(negedge clk);
    n_checks++; if ({s_dreq, s_daddr, s_be} !== {1'b1, 32'h1000, 4'b1100}) begin n_fail++;
      $display("FAIL mw beat0: got req=%b addr=%h be=%b required 1/00001000/1100", s_dreq, s_daddr, s_be); end
    s_gnt = 1;
    @(negedge clk);
    s_gnt = 0; s_rvalid = 1; s_drdata = 32'h55667788;
    @(negedge clk);
    n_checks++; if ({s_dreq, s_daddr, s_be} !== {1'b1, 32'h1004, 4'b0011}) begin n_fail++;
      $display("FAIL mw beat1: got req=%b addr=%h be=%b required 1/00001004/0011", s_dreq, s_daddr, s_be); end
    n_checks++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL mw early_done: got %b required 0", s_done); end
    s_rvalid = 0; s_gnt = 1;
    @(negedge clk);
    s_gnt = 0; s_rvalid = 1; s_drdata = 32'h11223344;
    @(negedge clk);
    n_checks++; if ({s_done, s_err} !== 2'b10) begin n_fail++; $display("FAIL mw done_err: got %b required 10", {s_done, s_err}); end
    n_checks++; if (s_rdata !== 32'h33445566) begin n_fail++; $display("FAIL mw rdata: got %h required 33445566", s_rdata); end
    s_rvalid = 0; s_req = 0;
    @(negedge clk);
`else
    @(negedge clk);
    n_checks++; if ({s_done, s_err} !== 2'b11) begin n_fail++; $display("FAIL mw err_pulse: got %b required 11", {s_done, s_err}); end
    n_checks++; if (s_rdata !== 32'h0) begin n_fail++; $display("FAIL mw err_rdata: got %h required 00000000", s_rdata); end
    n_checks++; if (s_dreq !== 1'b0) begin n_fail++; $display("FAIL mw no_req: got %b required 0", s_dreq); end
    s_req = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if ({s_dreq, s_done, s_busy} !== 3'b000) begin n_fail++;
        $display("FAIL mw quiet c%0d: got req/done/busy %b required 000", c, {s_dreq, s_done, s_busy}); end
    end
`endif
  endtask

  task automatic test_load_word64(input logic [2:0] size, input logic [63:0] exp);
    w_req = 1; w_we = 0; w_size = size; w_addr = 64'h8004;
    @(negedge clk);
    n_checks++; if ({w_dreq, w_be, w_daddr} !== {1'b1, 8'hF0, 64'h8000}) begin n_fail++;
      $display("FAIL lw64 sz%0d beat: got req=%b be=%h addr=%h required 1/f0/8000", size, w_dreq, w_be, w_daddr); end
    w_gnt = 1;
    @(negedge clk);
    w_gnt = 0; w_rvalid = 1; w_drdata = 64'hF0000000_12345678;
    @(negedge clk);
    n_checks++; if ({w_done, w_err} !== 2'b10) begin n_fail++; $display("FAIL lw64 sz%0d done_err: got %b required 10", size, {w_done, w_err}); end
    n_checks++; if (w_rdata !== exp) begin n_fail++; $display("FAIL lw64 sz%0d rdata: got %h required %h", size, w_rdata, exp); end
    w_rvalid = 0; w_drdata = '0; w_req = 0;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [2:0] sizes [3];
    logic       wes   [3];
    sizes[0] = MEM_ACCESS_UBYTE; wes[0] = 1'b1;
    sizes[1] = 3'd7;             wes[1] = 1'b0;
    sizes[2] = MEM_ACCESS_DWORD; wes[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_req = 1; s_we = wes[k]; s_size = sizes[k]; s_addr = 32'h1000; s_wdata = 32'hFF;
      @(negedge clk);
      n_checks++; if ({s_done, s_err, s_dreq} !== 3'b110) begin n_fail++;
        $display("FAIL illegal k%0d: got done/err/req %b required 110", k, {s_done, s_err, s_dreq}); end
      s_req = 0; s_we = 0;
      @(negedge clk);
      n_checks++; if ({s_done, s_err, s_dreq} !== 3'b000) begin n_fail++;
        $display("FAIL illegal_after k%0d: got done/err/req %b required 000", k, {s_done, s_err, s_dreq}); end
    end
  endtask

  task automatic test_reset_in_wait();
    s_req = 1; s_we = 0; s_size = MEM_ACCESS_WORD; s_addr = 32'h2000;
    @(negedge clk);
    s_gnt = 1;
    @(negedge clk);
    n_checks++; if ({s_dreq, s_busy} !== 2'b01) begin n_fail++; $display("FAIL rw in_wait: got req/busy %b required 01", {s_dreq, s_busy}); end
    s_gnt = 0; s_req = 0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({s_rdata, s_done, s_err, s_busy, s_dreq, s_dwe, s_be, s_daddr, s_dwdata} !== '0) begin
      n_fail++; $display("FAIL rw async_reset: got busy=%b req=%b addr=%h be=%b, required all 0", s_busy, s_dreq, s_daddr, s_be);
    end
    s_rvalid = 1; s_drdata = 32'hDEADBEEF;
    @(negedge clk);
    rst = 1'b0; s_rvalid = 0; s_drdata = '0;
    @(negedge clk);
    n_checks++; if ({s_done, s_busy} !== 2'b00) begin n_fail++; $display("FAIL rw no_done: got done/busy %b required 00", {s_done, s_busy}); end
    s_req = 1; s_size = MEM_ACCESS_HALF; s_addr = 32'h2002;
    @(negedge clk);
    n_checks++; if ({s_dreq, s_daddr, s_be} !== {1'b1, 32'h2000, 4'b1100}) begin n_fail++;
      $display("FAIL rw new_req: got req=%b addr=%h be=%b required 1/00002000/1100", s_dreq, s_daddr, s_be); end
    s_gnt = 1;
    @(negedge clk);
    s_gnt = 0; s_rvalid = 1; s_drdata = 32'h80010000;
    @(negedge clk);
    n_checks++; if ({s_done, s_rdata} !== {1'b1, 32'hFFFF8001}) begin n_fail++;
      $display("FAIL rw new_done: got done=%b rdata=%h required 1/ffff8001", s_done, s_rdata); end
    s_rvalid = 0; s_req = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misalign_word();
    test_load_word64(MEM_ACCESS_UWORD, 64'h00000000_F0000000);
    test_load_word64(MEM_ACCESS_WORD,  64'hFFFFFFFF_F0000000);
    test_illegal();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
